wb_scheduler: RTL and testbench
===============================

Name: wb_scheduler

Overview:
- Owns the single regfile write port and arbitrates it between two writeback requesters: EXU (ALU/CSR results) and LSU (load data returned over AXI-lite).
- Keeps a per-register pending scoreboard that is set at issue and cleared at regfile write.
- Gives decode a RAW/WAW stall, so the core needs no forwarding path.
- Sits between the EXU/LSU stages and the regfile write port (wen/waddr/wdata).

Parameters:
- REG_NUM, 32, number of architectural registers.
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W = REG_NUM.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- exu_valid  input  1  EXU writeback request
- exu_ready  output  1  EXU request granted this cycle
- exu_rd  input  ADDR_W  EXU destination register
- exu_data  input  DATA_W  EXU result
- lsu_valid  input  1  LSU writeback request
- lsu_ready  output  1  LSU request granted this cycle
- lsu_rd  input  ADDR_W  LSU destination register
- lsu_data  input  DATA_W  load result
- iss_valid  input  1  decode wants to issue an instruction
- iss_rd  input  ADDR_W  destination of the issuing instruction
- iss_wb  input  1  issuing instruction writes rd
- iss_rs1  input  ADDR_W  source register 1
- iss_rs2  input  ADDR_W  source register 2
- iss_use1  input  1  rs1 is read
- iss_use2  input  1  rs2 is read
- iss_stall  output  1  hazard; decode must hold
- rf_wen  output  1  regfile write enable
- rf_waddr  output  ADDR_W  regfile write address
- rf_wdata  output  DATA_W  regfile write data
- sb_err  output  1  sticky: writeback to a non-pending register

Behaviour:
- Reset (asynchronous, while rst_n=0): rf_wen=0, rf_waddr=0, rf_wdata=0, sb_err=0, all pending bits=0, priority pointer=EXU. exu_ready and lsu_ready are forced to 0 while rst_n=0. Asserting reset mid-operation discards all in-flight requests and pending state.
- Arbitration is combinational. With one requester valid, that requester gets ready=1. With both valid, the requester indicated by the priority pointer is granted.
  - After every grant, the pointer moves to the non-granted requester.
  - A requester never waits more than 1 cycle.
  - Accept = valid && ready. Requesters hold valid, rd and data stable until accepted.
- Writeback latency is 1 cycle. An accept at edge N gives rf_wen=1 with the registered rd/data during cycle N+1. The regfile writes at edge N+1.
- rd=0 is accepted and consumed; rf_wen stays 0 in the following cycle.
- Scoreboard: pending[REG_NUM], where bit 0 is hardwired to 0.
  - iss_fire = iss_valid && !iss_stall.
  - On iss_fire with iss_wb=1 and iss_rd!=0, pending[iss_rd] is set.
  - pending[rf_waddr] is cleared on any edge where rf_wen=1.
  - If set and clear hit the same register on the same edge, set wins.
- iss_stall is combinational and is computed only when iss_valid=1 (otherwise 0). It is asserted when any of these holds:
  - iss_use1 && pending[iss_rs1]
  - iss_use2 && pending[iss_rs2]
  - iss_wb && pending[iss_rd]
  - Registers are never pending at x0.
- A register being written this cycle is still pending and therefore still stalls. Its value is readable from the regfile on the next cycle, so no bypass is needed.
- At most one outstanding writer exists per register, guaranteed by the WAW stall.
- sb_err is set when an accepted request has rd!=0 and pending[rd]=0. It stays set until reset. The write is still performed.

Decomposition:
- Add REG_ADDR/RV32 bus widths and REG_NUM to the shared defines header. Add a 1-bit writeback-source encoding (WB_SRC_EXU=0, WB_SRC_LSU=1) for the priority pointer.
- Sub-module wb_rr_arb2: a 2-way round-robin arbiter holding the priority pointer flop, with outputs gnt_exu/gnt_lsu. Scoreboard and output registers stay in wb_scheduler.

Test Plan:
1. Reset, then issue rd=5 (iss_wb=1); next cycle issue with rs1=5, use1=1 -> iss_stall=1. EXU writes rd=5, data 0xDEADBEEF -> rf_wen=1, waddr=5, wdata=0xDEADBEEF one cycle after accept, stall still 1 that cycle, then 0.
2. Pend x3 and x4. exu_valid(rd=3, 0x11) and lsu_valid(rd=4, 0x22) both asserted from reset -> EXU granted first, LSU next cycle. rf writes are 3/0x11 then 4/0x22 on consecutive cycles.
3. Hold both valid continuously over 6 grants -> grants alternate EXU, LSU, EXU, LSU, EXU, LSU.
4. EXU writeback with rd=0 -> exu_ready=1, rf_wen stays 0, sb_err stays 0. Issue with rs1=0, use1=1 -> no stall.
5. Pend x7; issue rd=7 again -> stalled (WAW). On the edge where rf_wen writes x7, a fresh issue of rd=7 is allowed the following cycle -> pending[7] reasserted. LSU writeback to unpended x9 -> sb_err=1, sticky.
6. Pend x2 with an LSU request held valid. Pulse rst_n=0 asynchronously mid-cycle -> rf_wen=0, readies=0, pending cleared immediately. After release, issue rs1=2 -> no stall.

Source files
------------

// File: rtl/wb_scheduler_pkg.sv
// Shared widths and encodings for the writeback scheduler slice.
// The writeback-source enum doubles as the round-robin priority pointer value.
package wb_scheduler_pkg;

    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int RV32_W     = 32;

    typedef enum logic {
        WB_SRC_EXU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_scheduler_if.sv
// Writeback, issue and regfile-port signals of the scheduler, bundled.
// slave is the scheduler's view; master is the surrounding pipeline's view.
interface wb_scheduler_if
    import wb_scheduler_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = RV32_W
);

    logic              exu_valid;
    logic              exu_ready;
    logic [ADDR_W-1:0] exu_rd;
    logic [DATA_W-1:0] exu_data;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0] lsu_data;

    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic              iss_wb;
    logic [ADDR_W-1:0] iss_rs1;
    logic [ADDR_W-1:0] iss_rs2;
    logic              iss_use1;
    logic              iss_use2;
    logic              iss_stall;

    logic              rf_wen;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              sb_err;

    modport slave (
        input  exu_valid, exu_rd, exu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  iss_valid, iss_rd, iss_wb, iss_rs1, iss_rs2, iss_use1, iss_use2,
        output exu_ready, lsu_ready, iss_stall,
        output rf_wen, rf_waddr, rf_wdata, sb_err
    );

    modport master (
        output exu_valid, exu_rd, exu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output iss_valid, iss_rd, iss_wb, iss_rs1, iss_rs2, iss_use1, iss_use2,
        input  exu_ready, lsu_ready, iss_stall,
        input  rf_wen, rf_waddr, rf_wdata, sb_err
    );

endinterface

// File: rtl/wb_scheduler_rr_arb2.sv
// Two-way round-robin arbiter between EXU and LSU writebacks.
// Grants are combinational; the pointer always moves to the requester that lost.
module wb_rr_arb2
    import wb_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_exu,
    input  logic req_lsu,
    output logic gnt_exu,
    output logic gnt_lsu
);

    wb_src_e prio;

    // NOTE: defaults come first so every path assigns both grants; a missing
    // branch in always_comb would otherwise infer a latch.
    always_comb begin
        gnt_exu = 1'b0;
        gnt_lsu = 1'b0;
        if (rst_n) begin
            if (req_exu && req_lsu) begin
                gnt_exu = (prio == WB_SRC_EXU);
                gnt_lsu = (prio == WB_SRC_LSU);
            end else begin
                gnt_exu = req_exu;
                gnt_lsu = req_lsu;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= WB_SRC_EXU;
        end else if (gnt_exu) begin
            prio <= WB_SRC_LSU;
        end else if (gnt_lsu) begin
            prio <= WB_SRC_EXU;
        end
    end

endmodule

// File: rtl/wb_scheduler.sv
// Regfile write-port owner: arbitrates EXU/LSU writebacks, registers the write,
// and keeps the per-register pending scoreboard that drives the decode stall.
module wb_scheduler #(
    parameter int REG_NUM = wb_scheduler_pkg::REG_NUM,
    parameter int ADDR_W  = wb_scheduler_pkg::REG_ADDR_W,
    parameter int DATA_W  = wb_scheduler_pkg::RV32_W
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_scheduler_if.slave   bus
);

    logic               gnt_exu;
    logic               gnt_lsu;
    logic               acc_exu;
    logic               acc_lsu;
    logic               acc;
    logic [ADDR_W-1:0]  acc_rd;
    logic [DATA_W-1:0]  acc_data;
    logic               iss_fire;
    logic               stall;
    logic [REG_NUM-1:0] pending;
    logic [REG_NUM-1:0] pending_nxt;
    logic               wen_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               err_q;

    wb_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_exu (bus.exu_valid),
        .req_lsu (bus.lsu_valid),
        .gnt_exu (gnt_exu),
        .gnt_lsu (gnt_lsu)
    );

    assign acc_exu  = bus.exu_valid && gnt_exu;
    assign acc_lsu  = bus.lsu_valid && gnt_lsu;
    assign acc      = acc_exu || acc_lsu;
    assign acc_rd   = acc_lsu ? bus.lsu_rd   : bus.exu_rd;
    assign acc_data = acc_lsu ? bus.lsu_data : bus.exu_data;

    // A register whose write is on the port this cycle still counts as pending.
    always_comb begin
        stall = 1'b0;
        if (bus.iss_valid) begin
            stall = (bus.iss_use1 && pending[bus.iss_rs1]) ||
                    (bus.iss_use2 && pending[bus.iss_rs2]) ||
                    (bus.iss_wb   && pending[bus.iss_rd]);
        end
    end

    assign iss_fire = bus.iss_valid && !stall;

    // Clear first, then set, so a same-edge re-issue of the retiring rd wins.
    always_comb begin
        pending_nxt = pending;
        if (wen_q) begin
            pending_nxt[waddr_q] = 1'b0;
        end
        if (iss_fire && bus.iss_wb && (bus.iss_rd != '0)) begin
            pending_nxt[bus.iss_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // NOTE: state flops use non-blocking assignments so each one samples the
    // pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pending <= pending_nxt;
            wen_q   <= acc && (acc_rd != '0);
            if (acc) begin
                waddr_q <= acc_rd;
                wdata_q <= acc_data;
                if ((acc_rd != '0) && !pending[acc_rd]) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.exu_ready = gnt_exu;
    assign bus.lsu_ready = gnt_lsu;
    assign bus.iss_stall = stall;
    assign bus.rf_wen    = wen_q;
    assign bus.rf_waddr  = waddr_q;
    assign bus.rf_wdata  = wdata_q;
    assign bus.sb_err    = err_q;

endmodule

// File: tb/tb_wb_scheduler.sv
// Self-checking bench for wb_scheduler: directed scenarios followed by random
// traffic, all compared against a per-edge behavioural model of the rules.
module tb_wb_scheduler;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    wb_scheduler_if bus ();

    wb_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit          m_pend [32];
    bit          m_exu_turn;
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_err;
    bit          last_acc_e;
    bit          last_acc_l;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_exu_turn = 1'b1;
        m_wen      = 1'b0;
        m_waddr    = '0;
        m_wdata    = '0;
        m_err      = 1'b0;
        last_acc_e = 1'b0;
        last_acc_l = 1'b0;
    endfunction

    function automatic bit exp_rdy_exu();
        if (!rst_n) return 1'b0;
        if (bus.exu_valid && bus.lsu_valid) return m_exu_turn;
        return bus.exu_valid;
    endfunction

    function automatic bit exp_rdy_lsu();
        if (!rst_n) return 1'b0;
        if (bus.exu_valid && bus.lsu_valid) return !m_exu_turn;
        return bus.lsu_valid;
    endfunction

    function automatic bit exp_stall();
        if (!bus.iss_valid) return 1'b0;
        return (bus.iss_use1 && m_pend[bus.iss_rs1]) ||
               (bus.iss_use2 && m_pend[bus.iss_rs2]) ||
               (bus.iss_wb   && m_pend[bus.iss_rd]);
    endfunction

    // Advance the model across one rising edge using the current inputs.
    function automatic void model_edge();
        bit          e, l, fire, wen_n;
        logic [4:0]  rd, old_waddr;
        e         = bus.exu_valid && exp_rdy_exu();
        l         = bus.lsu_valid && exp_rdy_lsu();
        fire      = bus.iss_valid && !exp_stall();
        old_waddr = m_waddr;
        wen_n     = 1'b0;
        if (e || l) begin
            rd = l ? bus.lsu_rd : bus.exu_rd;
            if (rd != 0 && !m_pend[rd]) m_err = 1'b1;
            wen_n      = (rd != 0);
            m_waddr    = rd;
            m_wdata    = l ? bus.lsu_data : bus.exu_data;
            m_exu_turn = l;
        end
        if (m_wen) m_pend[old_waddr] = 1'b0;
        if (fire && bus.iss_wb && bus.iss_rd != 0) m_pend[bus.iss_rd] = 1'b1;
        m_wen      = wen_n;
        last_acc_e = e;
        last_acc_l = l;
    endfunction

    task automatic compare_all();
        check("exu_ready", bus.exu_ready, exp_rdy_exu());
        check("lsu_ready", bus.lsu_ready, exp_rdy_lsu());
        check("iss_stall", bus.iss_stall, exp_stall());
        check("rf_wen",    bus.rf_wen,    m_wen);
        if (m_wen) begin
            check("rf_waddr", bus.rf_waddr, m_waddr);
            check("rf_wdata", bus.rf_wdata, m_wdata);
        end
        check("sb_err", bus.sb_err, m_err);
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.exu_valid = 1'b0; bus.exu_rd = '0; bus.exu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.iss_wb = 1'b0;
        bus.iss_rs1 = '0; bus.iss_rs2 = '0; bus.iss_use1 = 1'b0; bus.iss_use2 = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic wb,
                         input logic [4:0] rs1, input logic use1,
                         input logic [4:0] rs2, input logic use2);
        bus.iss_valid = 1'b1;
        bus.iss_rd = rd;   bus.iss_wb = wb;
        bus.iss_rs1 = rs1; bus.iss_use1 = use1;
        bus.iss_rs2 = rs2; bus.iss_use2 = use2;
    endtask

    task automatic no_issue();
        bus.iss_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Prefer a pending destination not already targeted elsewhere.
    function automatic logic [4:0] pick_rd(input logic [4:0] avoid);
        int start;
        logic [4:0] r;
        if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
        start = $urandom_range(0, 31);
        for (int k = 0; k < 32; k++) begin
            r = 5'((start + k) % 32);
            if (r != 0 && m_pend[r] && r != avoid && !(m_wen && r == m_waddr)) return r;
        end
        return 5'd0;
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        bus.exu_valid = 1'b1;
        bus.lsu_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rf_wen",    bus.rf_wen,    1'b0);
        check("rst_rf_waddr",  bus.rf_waddr,  32'd0);
        check("rst_rf_wdata",  bus.rf_wdata,  32'd0);
        check("rst_sb_err",    bus.sb_err,    1'b0);
        check("rst_exu_ready", bus.exu_ready, 1'b0);
        check("rst_lsu_ready", bus.lsu_ready, 1'b0);
        idle();
        rst_n = 1'b1;

        // 1: RAW stall on x5 until its writeback has retired.
        issue(5, 1, 0, 0, 0, 0);
        cycle();
        issue(0, 0, 5, 1, 0, 0);
        #1 check("t1_raw_stall", bus.iss_stall, 1'b1);
        cycle();
        bus.exu_valid = 1'b1; bus.exu_rd = 5; bus.exu_data = 32'hDEADBEEF;
        #1 check("t1_exu_ready", bus.exu_ready, 1'b1);
        cycle();
        bus.exu_valid = 1'b0;
        #1;
        check("t1_wen",   bus.rf_wen,    1'b1);
        check("t1_waddr", bus.rf_waddr,  32'd5);
        check("t1_wdata", bus.rf_wdata,  32'hDEADBEEF);
        check("t1_stall_during_write", bus.iss_stall, 1'b1);
        cycle();
        #1 check("t1_stall_released", bus.iss_stall, 1'b0);
        cycle();
        idle();

        // 2: simultaneous requests straight from reset, EXU first.
        do_reset();
        issue(3, 1, 0, 0, 0, 0);
        cycle();
        issue(4, 1, 0, 0, 0, 0);
        cycle();
        no_issue();
        bus.exu_valid = 1'b1; bus.exu_rd = 3; bus.exu_data = 32'h11;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 4; bus.lsu_data = 32'h22;
        #1;
        check("t2_exu_first", bus.exu_ready, 1'b1);
        check("t2_lsu_waits", bus.lsu_ready, 1'b0);
        cycle();
        bus.exu_valid = 1'b0;
        #1;
        check("t2_lsu_next", bus.lsu_ready, 1'b1);
        check("t2_waddr_a",  bus.rf_waddr,  32'd3);
        check("t2_wdata_a",  bus.rf_wdata,  32'h11);
        cycle();
        bus.lsu_valid = 1'b0;
        #1;
        check("t2_wen_b",   bus.rf_wen,   1'b1);
        check("t2_waddr_b", bus.rf_waddr, 32'd4);
        check("t2_wdata_b", bus.rf_wdata, 32'h22);
        cycle();

        // 3: both requesters held valid; grants must alternate.
        bus.exu_valid = 1'b1; bus.exu_rd = 0; bus.exu_data = 32'hA5A5;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 0; bus.lsu_data = 32'h5A5A;
        for (int g = 0; g < 6; g++) begin
            #1;
            check("t3_exu_gnt", bus.exu_ready, (g % 2) == 0);
            check("t3_lsu_gnt", bus.lsu_ready, (g % 2) == 1);
            cycle();
        end
        idle();

        // 4: writeback to x0 is consumed without a regfile write.
        bus.exu_valid = 1'b1; bus.exu_rd = 0; bus.exu_data = 32'h55;
        #1 check("t4_exu_ready", bus.exu_ready, 1'b1);
        cycle();
        bus.exu_valid = 1'b0;
        issue(0, 0, 0, 1, 0, 0);
        #1;
        check("t4_no_wen",   bus.rf_wen,    1'b0);
        check("t4_no_err",   bus.sb_err,    1'b0);
        check("t4_x0_stall", bus.iss_stall, 1'b0);
        cycle();
        idle();

        // 5: WAW stall on x7, same-edge re-issue, and sticky sb_err.
        issue(7, 1, 0, 0, 0, 0);
        cycle();
        #1 check("t5_waw_stall", bus.iss_stall, 1'b1);
        bus.exu_valid = 1'b1; bus.exu_rd = 7; bus.exu_data = 32'h77;
        cycle();
        bus.exu_valid = 1'b0;
        #1;
        check("t5_wen_x7",        bus.rf_wen,    1'b1);
        check("t5_waddr_x7",      bus.rf_waddr,  32'd7);
        check("t5_stall_on_write", bus.iss_stall, 1'b1);
        cycle();
        #1 check("t5_reissue_ok", bus.iss_stall, 1'b0);
        cycle();
        issue(0, 0, 7, 1, 0, 0);
        #1 check("t5_x7_repended", bus.iss_stall, 1'b1);
        cycle();
        no_issue();
        bus.lsu_valid = 1'b1; bus.lsu_rd = 9; bus.lsu_data = 32'h99;
        cycle();
        bus.lsu_valid = 1'b0;
        #1 check("t5_sb_err_set", bus.sb_err, 1'b1);
        cycle();
        cycle();
        check("t5_sb_err_sticky", bus.sb_err, 1'b1);
        bus.exu_valid = 1'b1; bus.exu_rd = 7; bus.exu_data = 32'h70;
        cycle();
        bus.exu_valid = 1'b0;
        cycle();

        // 6: asynchronous reset mid-cycle with a write in flight.
        do_reset();
        issue(2, 1, 0, 0, 0, 0);
        cycle();
        issue(6, 1, 0, 0, 0, 0);
        cycle();
        no_issue();
        bus.exu_valid = 1'b1; bus.exu_rd = 6; bus.exu_data = 32'h66;
        cycle();
        bus.exu_valid = 1'b0;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 2; bus.lsu_data = 32'h2222;
        issue(0, 0, 2, 1, 0, 0);
        #1;
        check("t6_pre_wen",   bus.rf_wen,    1'b1);
        check("t6_pre_ready", bus.lsu_ready, 1'b1);
        check("t6_pre_stall", bus.iss_stall, 1'b1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_wen",   bus.rf_wen,    1'b0);
        check("t6_rst_lsu",   bus.lsu_ready, 1'b0);
        check("t6_rst_exu",   bus.exu_ready, 1'b0);
        check("t6_rst_stall", bus.iss_stall, 1'b0);
        check("t6_rst_waddr", bus.rf_waddr,  32'd0);
        bus.lsu_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1 check("t6_post_stall", bus.iss_stall, 1'b0);
        cycle();
        idle();

        // Random traffic obeying the hold-until-accepted protocol.
        for (int i = 0; i < 800; i++) begin
            if (!bus.exu_valid || last_acc_e) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.exu_valid = 1'b1;
                    bus.exu_rd    = pick_rd(bus.lsu_valid ? bus.lsu_rd : 5'd0);
                    bus.exu_data  = $urandom;
                end else begin
                    bus.exu_valid = 1'b0;
                end
            end
            if (!bus.lsu_valid || last_acc_l) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.lsu_valid = 1'b1;
                    bus.lsu_rd    = pick_rd(bus.exu_valid ? bus.exu_rd : 5'd0);
                    bus.lsu_data  = $urandom;
                end else begin
                    bus.lsu_valid = 1'b0;
                end
            end
            bus.iss_valid = 1'($urandom_range(0, 1));
            bus.iss_rd    = 5'($urandom_range(0, 31));
            bus.iss_wb    = ($urandom_range(0, 3) != 0);
            bus.iss_rs1   = 5'($urandom_range(0, 31));
            bus.iss_rs2   = 5'($urandom_range(0, 31));
            bus.iss_use1  = 1'($urandom_range(0, 1));
            bus.iss_use2  = 1'($urandom_range(0, 1));
            cycle();
        end
        idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
